// File: rtl/accum18_axis.sv
// accum18_axis: sums TERMS consecutive adder results into one dot-product
// element and presents each element on an AXI-Stream master. m_tlast marks
// the last element of each row of ROW_LEN elements.
// Optional build macro ACCUM18_SATURATE_EN: the accumulation clamps at
// 2^ACC_W-1 instead of wrapping modulo 2^ACC_W.
module accum18_axis #(
   parameter int IN_W    = 18,
   parameter int ACC_W   = 24,
   parameter int TERMS   = 3,
   parameter int ROW_LEN = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [ACC_W-1:0] m_tdata,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             m_tlast
);

   localparam int TW = (TERMS > 1) ? $clog2(TERMS) : 1;
   localparam int RW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
   localparam logic [TW-1:0] LAST_TERM = TW'(TERMS - 1);
   localparam logic [RW-1:0] LAST_COL  = RW'(ROW_LEN - 1);

   logic [ACC_W-1:0] r_acc;
   logic [TW-1:0]    r_term_cnt;
   logic [RW-1:0]    r_row_cnt;
   logic [ACC_W-1:0] r_tdata;
   logic             r_tvalid;
   logic             r_tlast;

   logic [ACC_W-1:0] w_data_ext;
   logic [ACC_W-1:0] w_acc_next;
   logic             w_last_term;
   logic             w_accept;
   logic             w_complete;

   // Running-sum step: wraps by default, clamps at full scale when the
   // saturating build is selected. A clamped sum stays clamped because any
   // further non-negative addend overflows again.
   function automatic logic [ACC_W-1:0] add_acc(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
`ifdef ACCUM18_SATURATE_EN
      logic [ACC_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      add_acc = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      add_acc = a + b;
`endif
   endfunction

   assign w_data_ext  = ACC_W'(s_data);
   assign w_last_term = (r_term_cnt == LAST_TERM);
   assign w_acc_next  = (r_term_cnt == '0) ? w_data_ext : add_acc(r_acc, w_data_ext);

   // Only the final beat of an element stalls while an older result waits;
   // partial terms keep flowing into the accumulator.
   assign s_ready    = !(w_last_term && r_tvalid && !m_tready);
   assign w_accept   = s_valid && s_ready;
   assign w_complete = w_accept && w_last_term;

   assign m_tdata  = r_tdata;
   assign m_tvalid = r_tvalid;
   assign m_tlast  = r_tlast;

   // Accumulator and term position advance on every accepted beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc      <= '0;
         r_term_cnt <= '0;
      end else if (w_accept) begin
         r_acc      <= w_acc_next;
         r_term_cnt <= w_last_term ? '0 : r_term_cnt + 1'b1;
      end
   end

   // Output register: loads a completed element (even during a handshake, so
   // back-to-back elements keep m_tvalid high), otherwise clears on handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tdata   <= '0;
         r_tvalid  <= 1'b0;
         r_tlast   <= 1'b0;
         r_row_cnt <= '0;
      end else if (w_complete) begin
         r_tdata   <= w_acc_next;
         r_tvalid  <= 1'b1;
         r_tlast   <= (r_row_cnt == LAST_COL);
         r_row_cnt <= (r_row_cnt == LAST_COL) ? '0 : r_row_cnt + 1'b1;
      end else if (r_tvalid && m_tready) begin
         r_tvalid  <= 1'b0;
         r_tlast   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_accum18_axis.sv
// Testbench for accum18_axis: directed scenarios plus a randomized run,
// scored against a beat-grouping reference model.
module tb_accum18_axis;

   localparam int T = 3;
   localparam int R = 3;
   localparam int W = 18;
   localparam longint MAXV = (64'd1 << W) - 1;
`ifdef ACCUM18_SATURATE_EN
   localparam logic [31:0] OVF_EXP = 32'h3FFFF;
`else
   localparam logic [31:0] OVF_EXP = 32'h3FFFD;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [17:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [17:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic        m_tlast;

   logic [17:0] s_data1 = '0;
   logic        s_valid1 = 1'b0;
   logic        s_ready1;
   logic [23:0] m_tdata1;
   logic        m_tvalid1;
   logic        m_tready1 = 1'b1;
   logic        m_tlast1;

   int checks = 0;
   int errors = 0;

   logic [31:0] beats[$];
   logic [31:0] exp_data[$];
   logic        exp_last[$];
   int          elem = 0;

   always #5 clk = ~clk;

   accum18_axis #(.IN_W(18), .ACC_W(18), .TERMS(T), .ROW_LEN(R)) u_dut (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast));

   accum18_axis #(.IN_W(18), .ACC_W(24), .TERMS(1), .ROW_LEN(2)) u_dut1 (
      .clk(clk), .reset(reset), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
      .m_tdata(m_tdata1), .m_tvalid(m_tvalid1), .m_tready(m_tready1), .m_tlast(m_tlast1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      beats.delete();
      exp_data.delete();
      exp_last.delete();
      elem = 0;
   endtask

   // Group accepted beats into elements; an element's value is the plain sum
   // of its beats, reduced by wrap or clamp.
   task automatic model_beat(input logic [17:0] d);
      longint sum;
      beats.push_back(32'(d));
      if (beats.size() == T) begin
         sum = 0;
         foreach (beats[i]) sum += longint'(beats[i]);
`ifdef ACCUM18_SATURATE_EN
         if (sum > MAXV) sum = MAXV;
`else
         sum = sum % (MAXV + 1);
`endif
         exp_data.push_back(32'(sum));
         exp_last.push_back(elem == R - 1);
         elem = (elem + 1) % R;
         beats.delete();
      end
   endtask

   // One clock cycle: called at a falling edge, returns at the next one.
   task automatic drive(input logic v, input logic [17:0] d, input logic rdy);
      logic exp_rdy;
      s_valid  = v;
      s_data   = d;
      m_tready = rdy;
      #1;
      exp_rdy = !((beats.size() == T - 1) && (exp_data.size() != 0) && !rdy);
      chk("s_ready", 32'(s_ready), 32'(exp_rdy));
      if (m_tvalid && m_tready) begin
         if (exp_data.size() == 0) begin
            chk("spurious_tvalid", 32'(m_tvalid), 32'd0);
         end else begin
            chk("hs_tdata", 32'(m_tdata), exp_data[0]);
            chk("hs_tlast", 32'(m_tlast), 32'(exp_last[0]));
            void'(exp_data.pop_front());
            void'(exp_last.pop_front());
         end
      end
      if (s_valid && s_ready) model_beat(d);
      @(posedge clk);
      #1;
      chk("tvalid", 32'(m_tvalid), 32'(exp_data.size() != 0));
      if (exp_data.size() != 0) begin
         chk("tdata", 32'(m_tdata), exp_data[0]);
         chk("tlast", 32'(m_tlast), 32'(exp_last[0]));
      end
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_tdata", 32'(m_tdata), 32'd0);
      chk("rst_tlast", 32'(m_tlast), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst1_tvalid", 32'(m_tvalid1), 32'd0);
      reset = 1'b0;
      model_reset();

      // Basic: 1..9 with m_tready high
      for (int i = 1; i <= 9; i++) begin
         drive(1'b1, 18'(i), 1'b1);
         if (i == 3) chk("basic_first", 32'(m_tdata), 32'd6);
         if (i == 9) chk("basic_last_flag", 32'(m_tlast), 32'd1);
      end
      drive(1'b0, '0, 1'b1);

      // Backpressure: 6 waits, 10 and 20 flow in, 30 stalls
      drive(1'b1, 18'd1, 1'b0);
      drive(1'b1, 18'd2, 1'b0);
      drive(1'b1, 18'd3, 1'b0);
      drive(1'b1, 18'd10, 1'b0);
      drive(1'b1, 18'd20, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 18'd30, 1'b0);
      chk("bp_s_ready", 32'(s_ready), 32'd0);
      chk("bp_hold", 32'(m_tdata), 32'd6);
      drive(1'b1, 18'd30, 1'b1);
      chk("bp_next", 32'(m_tdata), 32'd60);
      drive(1'b0, '0, 1'b1);

      // Simultaneous handshake and completion
      drive(1'b1, 18'd1, 1'b0);
      drive(1'b1, 18'd2, 1'b0);
      drive(1'b1, 18'd3, 1'b0);
      drive(1'b1, 18'd4, 1'b0);
      drive(1'b1, 18'd5, 1'b0);
      drive(1'b1, 18'd6, 1'b1);
      chk("sim_tvalid", 32'(m_tvalid), 32'd1);
      chk("sim_tdata", 32'(m_tdata), 32'd15);
      drive(1'b0, '0, 1'b1);

      // Overflow of the 18-bit accumulator
      for (int i = 0; i < 3; i++) drive(1'b1, 18'h3FFFF, 1'b1);
      chk("ovf", 32'(m_tdata), OVF_EXP);
      drive(1'b0, '0, 1'b1);

      // Two random elements to move the row position to 1
      for (int i = 0; i < 6; i++) drive(1'b1, 18'($urandom_range(0, 1000)), 1'b1);
      drive(1'b0, '0, 1'b1);

      // Reset mid-element with an output pending
      drive(1'b1, 18'd2, 1'b0);
      drive(1'b1, 18'd2, 1'b0);
      drive(1'b1, 18'd2, 1'b0);
      drive(1'b1, 18'd5, 1'b0);
      drive(1'b1, 18'd5, 1'b0);
      chk("pre_rst_tvalid", 32'(m_tvalid), 32'd1);
      s_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("async_rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("async_rst_tdata", 32'(m_tdata), 32'd0);
      chk("async_rst_tlast", 32'(m_tlast), 32'd0);
      chk("async_rst_s_ready", 32'(s_ready), 32'd1);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) drive(1'b1, 18'd1, 1'b1);
      chk("post_rst_tdata", 32'(m_tdata), 32'd3);
      chk("post_rst_tlast", 32'(m_tlast), 32'd0);
      drive(1'b0, '0, 1'b1);

      // TERMS=1, ROW_LEN=2 instance: pass-through with 1-cycle latency
      s_valid1 = 1'b1;
      s_data1  = 18'd7;
      #1;
      chk("t1_s_ready", 32'(s_ready1), 32'd1);
      drive(1'b0, '0, 1'b1);
      chk("t1_tvalid_a", 32'(m_tvalid1), 32'd1);
      chk("t1_tdata_a", 32'(m_tdata1), 32'd7);
      chk("t1_tlast_a", 32'(m_tlast1), 32'd0);
      s_data1 = 18'd9;
      drive(1'b0, '0, 1'b1);
      chk("t1_tvalid_b", 32'(m_tvalid1), 32'd1);
      chk("t1_tdata_b", 32'(m_tdata1), 32'd9);
      chk("t1_tlast_b", 32'(m_tlast1), 32'd1);
      s_valid1 = 1'b0;
      drive(1'b0, '0, 1'b1);
      chk("t1_tvalid_idle", 32'(m_tvalid1), 32'd0);

      // Randomized traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         logic [17:0] d;
         d = ($urandom_range(0, 3) == 0) ? 18'h3FFFF : 18'($urandom());
         drive($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 6);
      end
      for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
